// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared states, bit positions and write-target indices for the timer config sequencer
package ttc_pkg;

    localparam int TTC_DIS_BIT = 0;
    localparam int TTC_RST_BIT = 4;

    localparam int NUM_SEL  = 7;
    localparam int SEL_CLK  = 0;
    localparam int SEL_CNTR = 1;
    localparam int SEL_INTV = 2;
    localparam int SEL_M1   = 3;
    localparam int SEL_M2   = 4;
    localparam int SEL_M3   = 5;
    localparam int SEL_IEN  = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STOP,
        ST_W_CLK,
        ST_W_INTV,
        ST_W_M1,
        ST_W_M2,
        ST_W_M3,
        ST_W_IEN,
        ST_RESTART,
        ST_RUN,
        ST_DONE,
        ST_CLR
    } seq_state_e;

    function automatic logic [NUM_SEL-1:0] sel_onehot(input int idx);
        return NUM_SEL'(1) << idx;
    endfunction

endpackage

// File: rtl/ttc_cfg_sequencer_if.sv
// rtl/ttc_cfg_sequencer_if.sv - config request, irq service and timer write port bundle
interface ttc_cfg_sequencer_if #(
    parameter int CNT_W  = 16,
    parameter int CTRL_W = 7,
    parameter int INTR_W = 6
);
    logic              cfg_req;
    logic [CTRL_W-1:0] cfg_clk_ctrl;
    logic [CTRL_W-1:0] cfg_cntr_ctrl;
    logic [CNT_W-1:0]  cfg_interval;
    logic [CNT_W-1:0]  cfg_match_1;
    logic [CNT_W-1:0]  cfg_match_2;
    logic [CNT_W-1:0]  cfg_match_3;
    logic [INTR_W-1:0] cfg_intr_en;
    logic              cfg_ack;
    logic              cfg_busy;

    logic              interrupt;
    logic [INTR_W-1:0] interrupt_reg;
    logic              irq_valid;
    logic [INTR_W-1:0] irq_status;
    logic              irq_ack;

    logic [CNT_W-1:0]  pwdata;
    logic              clk_ctrl_reg_sel;
    logic              cntr_ctrl_reg_sel;
    logic              interval_reg_sel;
    logic              match_1_reg_sel;
    logic              match_2_reg_sel;
    logic              match_3_reg_sel;
    logic              intr_en_reg_sel;
    logic              clear_interrupt;

    modport master (
        output cfg_req, cfg_clk_ctrl, cfg_cntr_ctrl, cfg_interval,
               cfg_match_1, cfg_match_2, cfg_match_3, cfg_intr_en,
               interrupt, interrupt_reg, irq_ack,
        input  cfg_ack, cfg_busy, irq_valid, irq_status, pwdata,
               clk_ctrl_reg_sel, cntr_ctrl_reg_sel, interval_reg_sel,
               match_1_reg_sel, match_2_reg_sel, match_3_reg_sel,
               intr_en_reg_sel, clear_interrupt
    );

    modport slave (
        input  cfg_req, cfg_clk_ctrl, cfg_cntr_ctrl, cfg_interval,
               cfg_match_1, cfg_match_2, cfg_match_3, cfg_intr_en,
               interrupt, interrupt_reg, irq_ack,
        output cfg_ack, cfg_busy, irq_valid, irq_status, pwdata,
               clk_ctrl_reg_sel, cntr_ctrl_reg_sel, interval_reg_sel,
               match_1_reg_sel, match_2_reg_sel, match_3_reg_sel,
               intr_en_reg_sel, clear_interrupt
    );

endinterface

// File: rtl/ttc_irq_latch.sv
// rtl/ttc_irq_latch.sv - captures timer interrupt status and tracks the pending clear request
module ttc_irq_latch #(
    parameter int INTR_W = 6
) (
    input  logic              pclk,
    input  logic              p_reset,
    input  logic              interrupt,
    input  logic [INTR_W-1:0] interrupt_reg,
    input  logic              irq_ack,
    input  logic              clr_done,
    output logic              irq_valid,
    output logic [INTR_W-1:0] irq_status,
    output logic              clear_pend
);
    logic       rearm;
    logic [1:0] rearm_cnt;

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            irq_valid  <= 1'b0;
            irq_status <= '0;
            clear_pend <= 1'b0;
            rearm      <= 1'b0;
            rearm_cnt  <= 2'd0;
        end else begin
            if (!irq_valid && interrupt && !clear_pend && !rearm) begin
                irq_valid  <= 1'b1;
                irq_status <= interrupt_reg;
            end else if (irq_valid && irq_ack) begin
                irq_valid  <= 1'b0;
                clear_pend <= 1'b1;
            end

            // The timer line may still read high for a cycle or two after the
            // clear pulse; rearm masks that so one event is captured once.
            if (clr_done) begin
                clear_pend <= 1'b0;
                rearm      <= 1'b1;
                rearm_cnt  <= 2'd2;
            end else if (rearm) begin
                if (!interrupt || rearm_cnt == 2'd1) begin
                    rearm     <= 1'b0;
                    rearm_cnt <= 2'd0;
                end else begin
                    rearm_cnt <= rearm_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ttc_cfg_sequencer.sv
// rtl/ttc_cfg_sequencer.sv - register-write sequencer and interrupt-clear arbiter for one timer
module ttc_cfg_sequencer
    import ttc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int CTRL_W  = 7,
    parameter int INTR_W  = 6,
    parameter int DIS_BIT = TTC_DIS_BIT,
    parameter int RST_BIT = TTC_RST_BIT
) (
    input  logic               pclk,
    input  logic               p_reset,
    ttc_cfg_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] DIS_MASK = CNT_W'(1) << DIS_BIT;
    localparam logic [CNT_W-1:0] RST_MASK = CNT_W'(1) << RST_BIT;

    seq_state_e         state;
    logic [CTRL_W-1:0]  clk_ctrl_q;
    logic [CTRL_W-1:0]  cntr_ctrl_q;
    logic [CNT_W-1:0]   interval_q;
    logic [CNT_W-1:0]   match_1_q;
    logic [CNT_W-1:0]   match_2_q;
    logic [CNT_W-1:0]   match_3_q;
    logic [INTR_W-1:0]  intr_en_q;
    logic [NUM_SEL-1:0] sel_q;
    logic [CNT_W-1:0]   pwdata_q;
    logic               cfg_ack_q;
    logic               cfg_busy_q;
    logic               clear_int_q;
    logic               clear_pend;
    logic               clr_done;
    logic [CNT_W-1:0]   cntr_ext;

    assign cntr_ext = CNT_W'(cntr_ctrl_q);
    assign clr_done = (state == ST_CLR);

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state       <= ST_IDLE;
            clk_ctrl_q  <= '0;
            cntr_ctrl_q <= '0;
            interval_q  <= '0;
            match_1_q   <= '0;
            match_2_q   <= '0;
            match_3_q   <= '0;
            intr_en_q   <= '0;
            sel_q       <= '0;
            pwdata_q    <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_busy_q  <= 1'b0;
            clear_int_q <= 1'b0;
        end else begin
            sel_q       <= '0;
            pwdata_q    <= '0;
            cfg_ack_q   <= 1'b0;
            clear_int_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // A pending interrupt clear owns the shared port first.
                    if (clear_pend) begin
                        state <= ST_CLR;
                    end else if (bus.cfg_req) begin
                        clk_ctrl_q  <= bus.cfg_clk_ctrl;
                        cntr_ctrl_q <= bus.cfg_cntr_ctrl;
                        interval_q  <= bus.cfg_interval;
                        match_1_q   <= bus.cfg_match_1;
                        match_2_q   <= bus.cfg_match_2;
                        match_3_q   <= bus.cfg_match_3;
                        intr_en_q   <= bus.cfg_intr_en;
                        cfg_busy_q  <= 1'b1;
                        state       <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    sel_q    <= sel_onehot(SEL_CNTR);
                    pwdata_q <= cntr_ext | DIS_MASK;
                    state    <= ST_W_CLK;
                end
                ST_W_CLK: begin
                    sel_q    <= sel_onehot(SEL_CLK);
                    pwdata_q <= CNT_W'(clk_ctrl_q);
                    state    <= ST_W_INTV;
                end
                ST_W_INTV: begin
                    sel_q    <= sel_onehot(SEL_INTV);
                    pwdata_q <= interval_q;
                    state    <= ST_W_M1;
                end
                ST_W_M1: begin
                    sel_q    <= sel_onehot(SEL_M1);
                    pwdata_q <= match_1_q;
                    state    <= ST_W_M2;
                end
                ST_W_M2: begin
                    sel_q    <= sel_onehot(SEL_M2);
                    pwdata_q <= match_2_q;
                    state    <= ST_W_M3;
                end
                ST_W_M3: begin
                    sel_q    <= sel_onehot(SEL_M3);
                    pwdata_q <= match_3_q;
                    state    <= ST_W_IEN;
                end
                ST_W_IEN: begin
                    sel_q    <= sel_onehot(SEL_IEN);
                    pwdata_q <= CNT_W'(intr_en_q);
                    state    <= ST_RESTART;
                end
                ST_RESTART: begin
                    sel_q    <= sel_onehot(SEL_CNTR);
                    pwdata_q <= cntr_ext | DIS_MASK | RST_MASK;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    // cfg_ack is raised on entry to DONE so it lines up with the final write.
                    sel_q     <= sel_onehot(SEL_CNTR);
                    pwdata_q  <= cntr_ext & ~RST_MASK;
                    cfg_ack_q <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    cfg_busy_q <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_CLR: begin
                    clear_int_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ttc_irq_latch #(
        .INTR_W(INTR_W)
    ) u_irq_latch (
        .pclk          (pclk),
        .p_reset       (p_reset),
        .interrupt     (bus.interrupt),
        .interrupt_reg (bus.interrupt_reg),
        .irq_ack       (bus.irq_ack),
        .clr_done      (clr_done),
        .irq_valid     (bus.irq_valid),
        .irq_status    (bus.irq_status),
        .clear_pend    (clear_pend)
    );

    assign bus.pwdata            = pwdata_q;
    assign bus.clk_ctrl_reg_sel  = sel_q[SEL_CLK];
    assign bus.cntr_ctrl_reg_sel = sel_q[SEL_CNTR];
    assign bus.interval_reg_sel  = sel_q[SEL_INTV];
    assign bus.match_1_reg_sel   = sel_q[SEL_M1];
    assign bus.match_2_reg_sel   = sel_q[SEL_M2];
    assign bus.match_3_reg_sel   = sel_q[SEL_M3];
    assign bus.intr_en_reg_sel   = sel_q[SEL_IEN];
    assign bus.clear_interrupt   = clear_int_q;
    assign bus.cfg_ack           = cfg_ack_q;
    assign bus.cfg_busy          = cfg_busy_q;

endmodule

// File: tb/tb_ttc_cfg_sequencer.sv
// tb/tb_ttc_cfg_sequencer.sv - scoreboard bench for the timer config sequencer
module tb_ttc_cfg_sequencer;

    typedef struct {
        logic [7:0]  sel;   // {clear, ien, m3, m2, m1, intv, cntr, clk}
        logic [15:0] data;
        int          off;   // cycles after cfg_busy rise, 0 = not checked
    } wr_t;

    logic pclk;
    logic p_reset;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   busy_rise;
    logic busy_d;
    logic valid_d;
    logic [7:0] obs;
    wr_t  e;

    wr_t        exp_wr[$];
    int         exp_ack[$];
    logic [5:0] exp_irq[$];

    ttc_cfg_sequencer_if #(.CNT_W(16), .CTRL_W(7), .INTR_W(6)) bus ();

    ttc_cfg_sequencer dut (
        .pclk    (pclk),
        .p_reset (p_reset),
        .bus     (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] port_obs();
        return {bus.clear_interrupt, bus.intr_en_reg_sel, bus.match_3_reg_sel,
                bus.match_2_reg_sel, bus.match_1_reg_sel, bus.interval_reg_sel,
                bus.cntr_ctrl_reg_sel, bus.clk_ctrl_reg_sel};
    endfunction

    // Monitor: pops expected port writes, acks and irq captures as the DUT shows them.
    initial begin
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        busy_rise = 0;
    end

    always @(negedge pclk) begin
        if (bus.cfg_busy === 1'b1 && busy_d !== 1'b1) busy_rise = cyc;
        busy_d = bus.cfg_busy;

        obs = port_obs();
        if (obs !== 8'h00) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_strobe", {24'h0, obs}, 32'h0);
            end else begin
                e = exp_wr.pop_front();
                chk("port_sel", {24'h0, obs}, {24'h0, e.sel});
                chk("port_pwdata", {16'h0, bus.pwdata}, {16'h0, e.data});
                if (e.off > 0) chk("strobe_offset", cyc - busy_rise, e.off);
            end
        end else begin
            chk("pwdata_idle", {16'h0, bus.pwdata}, 32'h0);
        end

        if (bus.cfg_ack === 1'b1) begin
            if (exp_ack.size() == 0) begin
                chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
                chk("ack_offset", cyc - busy_rise, exp_ack.pop_front());
                chk("busy_at_ack", {31'h0, bus.cfg_busy}, 32'h1);
            end
        end

        if (bus.irq_valid === 1'b1 && valid_d !== 1'b1) begin
            if (exp_irq.size() == 0)
                chk("unexpected_irq_capture", 32'h1, 32'h0);
            else
                chk("irq_status", {26'h0, bus.irq_status}, {26'h0, exp_irq.pop_front()});
        end
        valid_d = bus.irq_valid;
    end

    // mode: 0 plain, 1 irq_ack during W_M2, 2 reset during W_INTV, 3 inputs changed while busy
    task automatic do_cfg(input logic [6:0] clk_c, input logic [6:0] cntr_c,
                          input logic [15:0] iv, input logic [15:0] m1,
                          input logic [15:0] m2, input logic [15:0] m3,
                          input logic [5:0] ien, input int mode);
        wr_t seq[9];
        int  n;
        bit  done;
        seq[0] = '{8'h02, {9'h0, cntr_c} | 16'h0001, 1};
        seq[1] = '{8'h01, {9'h0, clk_c}, 2};
        seq[2] = '{8'h04, iv, 3};
        seq[3] = '{8'h08, m1, 4};
        seq[4] = '{8'h10, m2, 5};
        seq[5] = '{8'h20, m3, 6};
        seq[6] = '{8'h40, {10'h0, ien}, 7};
        seq[7] = '{8'h02, {9'h0, cntr_c} | 16'h0011, 8};
        seq[8] = '{8'h02, {9'h0, cntr_c} & 16'hFFEF, 9};
        n = (mode == 2) ? 2 : 9;
        for (int i = 0; i < n; i++) exp_wr.push_back(seq[i]);
        if (mode == 1) exp_wr.push_back('{8'h80, 16'h0000, 0});
        if (mode != 2) exp_ack.push_back(9);

        bus.cfg_clk_ctrl  = clk_c;
        bus.cfg_cntr_ctrl = cntr_c;
        bus.cfg_interval  = iv;
        bus.cfg_match_1   = m1;
        bus.cfg_match_2   = m2;
        bus.cfg_match_3   = m3;
        bus.cfg_intr_en   = ien;
        bus.cfg_req       = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            bus.irq_ack = (mode == 1 && bus.match_1_reg_sel === 1'b1);
            if (mode == 3 && bus.cntr_ctrl_reg_sel === 1'b1) begin
                bus.cfg_cntr_ctrl = 7'h55;
                bus.cfg_interval  = 16'hDEAD;
                bus.cfg_clk_ctrl  = 7'h7F;
            end
            if (mode == 2 && bus.clk_ctrl_reg_sel === 1'b1) begin
                p_reset       = 1'b1;
                bus.cfg_req   = 1'b0;
                bus.interrupt = 1'b0;
                done = 1'b1;
            end
            if (bus.cfg_ack === 1'b1) begin
                bus.cfg_req = 1'b0;
                done = 1'b1;
            end
        end
        bus.cfg_req = 1'b0;
        if (!done) chk("cfg_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (bus.irq_valid !== 1'b1 && k < 10);
        if (bus.irq_valid !== 1'b1) chk(name, {31'h0, bus.irq_valid}, 32'h1);
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (bus.clear_interrupt !== 1'b1 && cnt < 20) begin
            @(negedge pclk);
            cnt++;
        end
    endtask

    int clr_cnt;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        p_reset           = 1'b1;
        bus.cfg_req       = 1'b0;
        bus.cfg_clk_ctrl  = '0;
        bus.cfg_cntr_ctrl = '0;
        bus.cfg_interval  = '0;
        bus.cfg_match_1   = '0;
        bus.cfg_match_2   = '0;
        bus.cfg_match_3   = '0;
        bus.cfg_intr_en   = '0;
        bus.interrupt     = 1'b0;
        bus.interrupt_reg = '0;
        bus.irq_ack       = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_ack", {31'h0, bus.cfg_ack}, 32'h0);
        chk("rst_busy", {31'h0, bus.cfg_busy}, 32'h0);
        chk("rst_sel", {24'h0, port_obs()}, 32'h0);
        chk("rst_pwdata", {16'h0, bus.pwdata}, 32'h0);
        chk("rst_irq_valid", {31'h0, bus.irq_valid}, 32'h0);
        chk("rst_irq_status", {26'h0, bus.irq_status}, 32'h0);
        p_reset = 1'b0;
        @(negedge pclk);

        // Basic configuration
        do_cfg(7'h05, 7'h0A, 16'h1234, 16'h0010, 16'h0020, 16'h0030, 6'h3F, 0);
        @(negedge pclk);
        chk("busy_after_ack", {31'h0, bus.cfg_busy}, 32'h0);

        // Interrupt capture, acknowledge, clear, no re-capture
        bus.interrupt_reg = 6'h04;
        bus.interrupt     = 1'b1;
        exp_irq.push_back(6'h04);
        wait_valid("irq_capture_t2");
        exp_wr.push_back('{8'h80, 16'h0000, 0});
        bus.irq_ack = 1'b1;
        @(negedge pclk);
        bus.irq_ack = 1'b0;
        chk("valid_clr_on_ack", {31'h0, bus.irq_valid}, 32'h0);
        wait_clear(clr_cnt);
        chk("ack_to_clear", clr_cnt, 2);
        @(negedge pclk);
        bus.interrupt = 1'b0;
        repeat (4) @(negedge pclk);
        chk("no_recapture_t2", {31'h0, bus.irq_valid}, 32'h0);

        // irq_ack while the sequence is in W_M2
        bus.interrupt_reg = 6'h21;
        bus.interrupt     = 1'b1;
        exp_irq.push_back(6'h21);
        wait_valid("irq_capture_t3");
        do_cfg(7'h03, 7'h40, 16'hBEEF, 16'h0001, 16'hFFFF, 16'h8000, 6'h15, 1);
        chk("no_clear_before_ack", {31'h0, bus.clear_interrupt}, 32'h0);
        wait_clear(clr_cnt);
        chk("ack_to_clear_cfg", clr_cnt, 3);
        @(negedge pclk);
        bus.interrupt = 1'b0;
        repeat (4) @(negedge pclk);
        chk("no_recapture_t3", {31'h0, bus.irq_valid}, 32'h0);

        // clear_pend and cfg_req together in IDLE
        bus.interrupt_reg = 6'h08;
        bus.interrupt     = 1'b1;
        exp_irq.push_back(6'h08);
        wait_valid("irq_capture_t4");
        exp_wr.push_back('{8'h80, 16'h0000, 0});
        bus.irq_ack = 1'b1;
        @(negedge pclk);
        bus.irq_ack   = 1'b0;
        bus.interrupt = 1'b0;
        do_cfg(7'h7F, 7'h00, 16'h0000, 16'hAAAA, 16'h5555, 16'h0F0F, 6'h00, 0);
        repeat (3) @(negedge pclk);

        // Reset during W_INTV aborts the sequence
        bus.interrupt_reg = 6'h11;
        bus.interrupt     = 1'b1;
        exp_irq.push_back(6'h11);
        wait_valid("irq_capture_t5");
        do_cfg(7'h01, 7'h02, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 6'h01, 2);
        @(negedge pclk);
        chk("abort_sel", {24'h0, port_obs()}, 32'h0);
        chk("abort_pwdata", {16'h0, bus.pwdata}, 32'h0);
        chk("abort_busy", {31'h0, bus.cfg_busy}, 32'h0);
        chk("abort_irq_valid", {31'h0, bus.irq_valid}, 32'h0);
        chk("abort_ack", {31'h0, bus.cfg_ack}, 32'h0);
        p_reset = 1'b0;
        repeat (12) @(negedge pclk);
        chk("abort_idle_busy", {31'h0, bus.cfg_busy}, 32'h0);

        // Inputs changed while busy are ignored
        do_cfg(7'h11, 7'h3C, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 6'h2A, 3);
        repeat (3) @(negedge pclk);

        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_ack_drained", exp_ack.size(), 0);
        chk("exp_irq_drained", exp_irq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
